// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundle between the round-robin write arbiter, its requesters and the
//   write side of the asynchronous FIFO.
//
//   req       NREQ         per-requester write request (level)
//   req_data  NREQ*DSIZE   per-requester word, requester i at [i*DSIZE +: DSIZE]
//   req_ack   NREQ         one-hot, word from requester i written this cycle
//   gnt       NREQ         one-hot current owner, zero when idle
//   owner     OWNW         index of current/last owner
//   busy      1            arbiter is in a burst
//   wdata     DSIZE        to FIFO wdata
//   winc      1            to FIFO winc
//   wfull     1            from FIFO wfull
//
//   slave  : the arbiter.
//   master : the environment around it (requesters plus FIFO write side),
//            which is why master also drives wfull.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int OWNW  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       gnt;
  logic [OWNW-1:0]       owner;
  logic                  busy;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  wfull;

  modport slave (
    input  req, req_data, wfull,
    output req_ack, gnt, owner, busy, wdata, winc
  );

  modport master (
    output req, req_data, wfull,
    input  req_ack, gnt, owner, busy, wdata, winc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing one FIFO write port between NREQ
//   producers on the FIFO write clock. One requester owns the port for up to
//   BURST words; at burst end the next requester is chosen in the same cycle
//   so consecutive bursts run back to back with no idle cycle.
//
//   Ports:
//     clk   write clock (same clock as the FIFO write side)
//     rst   synchronous reset, active-high
//     bus   fifo_wr_arbiter_if.slave: req/req_data/req_ack from requesters,
//           gnt/owner/busy status, wdata/winc/wfull to/from the FIFO
//
//   Parameters: NREQ requesters, DSIZE data width, BURST words per grant,
//   OWNW owner index width (NREQ <= 2**OWNW).
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int OWNW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int              CNTW      = $clog2(BURST) + 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST - 1);
  localparam logic [OWNW-1:0] LAST_REQ  = OWNW'(NREQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [OWNW-1:0] owner_reg, owner_next;
  logic [OWNW-1:0] ptr_reg, ptr_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;

  logic [DSIZE-1:0] data_slice [NREQ];
  logic [NREQ-1:0]  owner_onehot;

  // First requesting index at or after p, wrapping modulo NREQ.
  // Returns {found, index}.
  function automatic logic [OWNW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OWNW-1:0] p);
    logic            found;
    logic [OWNW-1:0] idx;
    int              k;
    found = 1'b0;
    idx   = p;
    for (int s = 0; s < NREQ; s++) begin
      k = (int'(p) + s) % NREQ;
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = OWNW'(k);
      end
    end
    return {found, idx};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_slice[gi]   = bus.req_data[gi*DSIZE +: DSIZE];
      assign owner_onehot[gi] = (owner_reg == OWNW'(gi));
    end
  endgenerate

  logic            sel_found, hand_found;
  logic [OWNW-1:0] sel_idx, hand_idx, hand_ptr;
  logic            owner_req, write_ok, burst_end;

  // Pointer used for the same-cycle handoff: the slot after the owner.
  assign hand_ptr = (owner_reg == LAST_REQ) ? '0 : owner_reg + 1'b1;

  assign {sel_found, sel_idx}   = rr_pick(bus.req, ptr_reg);
  assign {hand_found, hand_idx} = rr_pick(bus.req, hand_ptr);

  // Reduction over the one-hot keeps the lookup in range when NREQ < 2**OWNW.
  assign owner_req = |(bus.req & owner_onehot);
  assign write_ok  = (state_reg == S_BURST) && owner_req && !bus.wfull;

  // A stalled beat (wfull) can never complete a burst; only a dropped
  // request or the final accepted word ends it.
  assign burst_end = (state_reg == S_BURST) &&
                     ((write_ok && (cnt_reg == LAST_BEAT)) || !owner_req);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (sel_found) begin
          state_next = S_BURST;
          owner_next = sel_idx;
          cnt_next   = '0;
        end
      end
      S_BURST: begin
        if (write_ok) begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (burst_end) begin
          ptr_next = hand_ptr;
          if (hand_found) begin
            owner_next = hand_idx;
            cnt_next   = '0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic; rst masks every strobe combinationally so nothing is
  // written in the reset cycle even mid-burst.
  always_comb begin
    bus.gnt     = '0;
    bus.req_ack = '0;
    bus.busy    = 1'b0;
    bus.winc    = 1'b0;
    bus.owner   = owner_reg;
    bus.wdata   = data_slice[0];
    for (int i = 0; i < NREQ; i++) begin
      if (owner_onehot[i]) begin
        bus.wdata = data_slice[i];
      end
    end
    if ((state_reg == S_BURST) && !rst) begin
      bus.gnt     = owner_onehot;
      bus.busy    = 1'b1;
      bus.winc    = write_ok;
      bus.req_ack = write_ok ? owner_onehot : '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Bench for fifo_wr_arbiter: directed scenarios plus a long randomized run.
//   Requesters and a 16-deep FIFO write side are modelled here; a
//   transaction-level arbiter model predicts every output each cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int OWNW  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .OWNW(OWNW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST), .OWNW(OWNW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Requester / FIFO environment
  logic [NREQ-1:0]  rq;
  logic [DSIZE-1:0] rd [NREQ];
  logic             wf;
  logic [NREQ-1:0]  last_ack;
  logic             s_winc, s_busy;
  logic [NREQ-1:0]  s_gnt;
  logic [OWNW-1:0]  s_owner;
  logic [DSIZE-1:0] act_q [$];
  logic [DSIZE-1:0] exp_q [$];
  int               who_q [$];

  // Arbiter model: who holds the port (-1 = nobody), words it has written
  // this grant, where the next search starts, and the last owner reported.
  int m_own   = -1;
  int m_words = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic int pick(logic [NREQ-1:0] r, int from);
    for (int s = 0; s < NREQ; s++) begin
      if (r[(from + s) % NREQ]) return (from + s) % NREQ;
    end
    return -1;
  endfunction

  // Compare process: checks every cycle, then advances the model
  always @(negedge clk) begin
    logic [NREQ-1:0]  eg, ea;
    logic             ew, eb;
    logic [DSIZE-1:0] ed;
    int               p;
    #3;
    if (chk_en) begin
      eg = '0; ea = '0; ew = 1'b0; eb = 1'b0;
      if (!rst && m_own >= 0) begin
        eg[m_own] = 1'b1;
        eb        = 1'b1;
        ew        = bus.req[m_own] && !bus.wfull;
        ea[m_own] = ew;
        ed        = bus.req_data[m_own*DSIZE +: DSIZE];
        chk("wdata", 32'(bus.wdata), 32'(ed));
        if (ew) exp_q.push_back(ed);
      end
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("winc", 32'(bus.winc), 32'(ew));
      chk("req_ack", 32'(bus.req_ack), 32'(ea));
      if (!rst) chk("owner", 32'(bus.owner), 32'(m_last));
      if (bus.winc === 1'b1) begin
        p = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) p = i;
        act_q.push_back(bus.wdata);
        who_q.push_back(p);
        $display("wr cyc=%0d req=%0d data=%02h", cyc, p, bus.wdata);
      end
      if (rst) begin
        m_own = -1; m_ptr = 0; m_last = 0; m_words = 0;
      end else if (m_own < 0) begin
        p = pick(bus.req, m_ptr);
        if (p >= 0) begin m_own = p; m_last = p; m_words = 0; end
      end else begin
        if (ew) m_words++;
        if (!bus.req[m_own] || m_words == BURST) begin
          m_ptr = (m_own + 1) % NREQ;
          p = pick(bus.req, m_ptr);
          if (p >= 0) begin m_own = p; m_last = p; m_words = 0; end
          else m_own = -1;
        end
      end
    end
    cyc++;
  end

  task automatic apply();
    bus.req   = rq;
    bus.wfull = wf;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DSIZE +: DSIZE] = rd[i];
  endtask

  // Inputs were applied at the falling edge; sample the DUT after the
  // compare process, then move to the next falling edge.
  task automatic next_cycle();
    #4;
    last_ack = bus.req_ack;
    s_winc   = bus.winc;
    s_gnt    = bus.gnt;
    s_busy   = bus.busy;
    s_owner  = bus.owner;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rq = '0; wf = 1'b0;
    apply();
    next_cycle();
    rst = 1'b0;
    last_ack = '0;
    act_q.delete(); exp_q.delete(); who_q.delete();
  endtask

  task automatic adv_acked();
    for (int i = 0; i < NREQ; i++) if (last_ack[i]) rd[i] = rd[i] + 1'b1;
  endtask

  task automatic fifo_read();
    logic [DSIZE-1:0] a;
    if (act_q.size() > 0) begin
      a = act_q.pop_front();
      if (exp_q.size() > 0) chk("fifo_data", 32'(a), 32'(exp_q.pop_front()));
      else chk("fifo_extra", 32'(act_q.size() + 1), 32'(0));
    end
  endtask

  task automatic upd_req(input int drop_pct, input int raise_pct, input int cont_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i]) begin
        rd[i] = rd[i] + 1'b1;
        rq[i] = ($urandom_range(99) < cont_pct);
      end else if (rq[i]) begin
        if ($urandom_range(99) < drop_pct) rq[i] = 1'b0;
      end else begin
        rq[i] = ($urandom_range(99) < raise_pct);
      end
    end
  endtask

  initial begin
    logic [15:0] tr;
    int          n;
    int          rr_exp [20];
    int          who_exp [7];
    logic [NREQ-1:0] sched [9];

    rst = 1'b1; rq = '0; wf = 1'b0;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    apply();
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(s_gnt), 32'(0));
    chk("rst_winc", 32'(s_winc), 32'(0));
    apply();
    next_cycle();
    chk("idle_owner", 32'(s_owner), 32'(0));
    chk("idle_busy", 32'(s_busy), 32'(0));

    // Single requester, six words across two grants with no gap
    do_reset();
    rd[0] = 8'h10; rq = 4'b0001; n = 0; tr = '0;
    for (int c = 0; c < 10; c++) begin
      if (last_ack[0]) begin
        rd[0] = rd[0] + 1'b1; n++;
        if (n == 6) rq[0] = 1'b0;
      end
      apply();
      next_cycle();
      tr[c] = s_winc;
      if (c == 8) chk("t1_gnt_idle", 32'(s_gnt), 32'(0));
    end
    chk("t1_winc_trace", 32'(tr[9:0]), 32'h07E);
    chk("t1_fifo_len", 32'(act_q.size()), 32'(6));
    for (int i = 0; i < 6 && i < act_q.size(); i++)
      chk("t1_fifo_word", 32'(act_q[i]), 32'(8'h10 + i));

    // Round robin with all four requesting
    do_reset();
    rr_exp = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0};
    rq = 4'b1111; n = 0;
    for (int c = 0; c < 22; c++) begin
      adv_acked();
      apply();
      next_cycle();
      if (c >= 1 && c <= 20 && s_winc) n++;
    end
    chk("t2_consecutive", 32'(n), 32'(20));
    for (int i = 0; i < 20 && i < who_q.size(); i++)
      chk("t2_owner_seq", 32'(who_q[i]), 32'(rr_exp[i]));

    // wfull stall inside requester 2's burst
    do_reset();
    rq = 4'b0100; tr = '0; n = 0;
    for (int c = 0; c < 12; c++) begin
      adv_acked();
      wf = (c >= 3 && c <= 7);
      apply();
      next_cycle();
      tr[c] = s_winc;
      if (c >= 1 && c <= 9 && s_gnt == 4'b0100) n++;
    end
    wf = 1'b0;
    chk("t3_winc_trace", 32'(tr[11:0]), 32'hF06);
    chk("t3_gnt_held", 32'(n), 32'(9));

    // Owner drops mid-burst while requester 3 waits
    do_reset();
    who_exp = '{1,1,3,3,3,3,1};
    rq = 4'b1010; tr = '0;
    for (int c = 0; c < 10; c++) begin
      adv_acked();
      if (c == 3) rq[1] = 1'b0;
      if (c == 4) rq[1] = 1'b1;
      apply();
      next_cycle();
      tr[c] = s_winc;
    end
    chk("t4_drop_nowrite", 32'(tr[3]), 32'(0));
    for (int i = 0; i < 7 && i < who_q.size(); i++)
      chk("t4_owner_seq", 32'(who_q[i]), 32'(who_exp[i]));

    // Reset mid-burst after the pointer has moved past 0
    do_reset();
    sched = '{4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0101,
              4'b0100, 4'b0101, 4'b0101, 4'b0101};
    for (int c = 0; c < 9; c++) begin
      adv_acked();
      rq  = sched[c];
      rst = (c == 6);
      apply();
      next_cycle();
      if (c == 5) chk("t5_owner2", 32'(s_gnt), 32'(4'b0100));
      if (c == 6) chk("t5_rst_winc", 32'(s_winc), 32'(0));
      if (c == 7) chk("t5_gnt_idle", 32'(s_gnt), 32'(0));
      if (c == 7) chk("t5_busy_idle", 32'(s_busy), 32'(0));
      if (c == 8) chk("t5_regrant0", 32'(s_gnt), 32'(4'b0001));
    end
    rst = 1'b0;

    // Two requesters filling a 16-deep FIFO with reads stopped
    do_reset();
    rq = 4'b0011; n = 0;
    for (int c = 0; c < 30; c++) begin
      adv_acked();
      wf = (act_q.size() >= DEPTH);
      apply();
      next_cycle();
      if (s_winc) n++;
    end
    chk("t6_writes", 32'(n), 32'(16));
    chk("t6_fifo_len", 32'(act_q.size()), 32'(16));
    chk("t6_stalled", 32'(s_winc), 32'(0));
    for (int c = 0; c < 40; c++) begin
      adv_acked();
      if (c >= 20) rq = '0;
      fifo_read();
      wf = (act_q.size() >= DEPTH);
      apply();
      next_cycle();
    end
    while (act_q.size() > 0) fifo_read();
    chk("t6_drain", 32'(exp_q.size()), 32'(0));

    // Randomized traffic with random stalls, reads and resets
    do_reset();
    for (int i = 0; i < NREQ; i++) rd[i] = 8'(i * 64);
    for (int c = 0; c < 3000; c++) begin
      upd_req(6, 35, 75);
      if ($urandom_range(1) == 1) fifo_read();
      wf  = (act_q.size() >= DEPTH) || ($urandom_range(5) == 0);
      rst = ($urandom_range(299) == 0);
      apply();
      next_cycle();
    end
    rst = 1'b0; rq = '0; wf = 1'b0;
    apply();
    next_cycle();
    next_cycle();
    while (act_q.size() > 0) fifo_read();
    chk("rand_drain", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
